// File: rtl/csr_exec_unit.sv
// Machine-mode CSR sequencer: read, modify and commit CSRs; raise ECALL/MRET traps and redirects.
// Build option: define CSR_ILLEGAL_CHECK_EN to trap on illegal CSR accesses.
module csr_exec_unit #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_funct3,
    input  logic              in_is_ecall,
    input  logic              in_is_mret,
    input  logic [ADDR_W-1:0] in_csr_addr,
    input  logic [4:0]        in_src_idx,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   in_pc,
    output logic [ADDR_W-1:0] csr_addr_read,
    output logic [ADDR_W-1:0] csr_addr_write,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              csr_we,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              trap_exception,
    output logic              trap_is_ecall,
    output logic              trap_is_mret,
    output logic              trap_illegal,
    input  logic [XLEN-1:0]   csr_next_pc,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              flush_valid,
    output logic [XLEN-1:0]   flush_pc
);

    typedef enum logic [2:0] {IDLE, READ, COMMIT, TRAP, FLUSH} state_t;

    state_t            state;
    logic [2:0]        funct3_q;
    logic [4:0]        src_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   pc_q;
    logic [ADDR_W-1:0] addr_q;

    logic              we_q, wb_q, exc_q, ecall_q, mret_q, ill_q, flush_q;
    logic [ADDR_W-1:0] addr_r_q, addr_w_q;
    logic [XLEN-1:0]   wdata_q, old_q, flush_pc_q;
    logic [4:0]        wb_rd_q;

    logic [XLEN-1:0]   src;
    logic [XLEN-1:0]   new_val;
    logic              suppress;
    logic              illegal;

    assign src      = funct3_q[2] ? {{(XLEN-5){1'b0}}, src_q} : rs1_q;
    assign suppress = funct3_q[1] && (src_q == 5'd0);

    always_comb begin
        new_val = src;
        unique case (funct3_q[1:0])
            2'b10:   new_val = csr_rdata | src;
            2'b11:   new_val = csr_rdata & ~src;
            default: new_val = src;
        endcase
    end

`ifdef CSR_ILLEGAL_CHECK_EN
    logic implemented;

    always_comb begin
        implemented = 1'b0;
        case (addr_q)
            12'h300, 12'h305, 12'h344, 12'h304,
            12'h340, 12'h342, 12'h343, 12'h341,
            12'hB00, 12'hF14, 12'h180: implemented = 1'b1;
            default:                   implemented = 1'b0;
        endcase
    end

    assign illegal = (funct3_q[1:0] == 2'b00)
                  || ((addr_q[11:10] == 2'b11) && !suppress)
                  || !implemented;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            funct3_q   <= '0;
            src_q      <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            pc_q       <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wb_q       <= 1'b0;
            exc_q      <= 1'b0;
            ecall_q    <= 1'b0;
            mret_q     <= 1'b0;
            ill_q      <= 1'b0;
            flush_q    <= 1'b0;
            addr_r_q   <= '0;
            addr_w_q   <= '0;
            wdata_q    <= '0;
            old_q      <= '0;
            flush_pc_q <= '0;
            wb_rd_q    <= '0;
        end else begin
            // Every strobe and its payload lives for exactly one cycle.
            we_q       <= 1'b0;
            wb_q       <= 1'b0;
            exc_q      <= 1'b0;
            ecall_q    <= 1'b0;
            mret_q     <= 1'b0;
            ill_q      <= 1'b0;
            flush_q    <= 1'b0;
            addr_r_q   <= '0;
            addr_w_q   <= '0;
            wdata_q    <= '0;
            old_q      <= '0;
            flush_pc_q <= '0;
            wb_rd_q    <= '0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        funct3_q <= in_funct3;
                        src_q    <= in_src_idx;
                        rd_q     <= in_rd;
                        rs1_q    <= in_rs1_val;
                        pc_q     <= in_pc;
                        addr_q   <= in_csr_addr;
                        if (in_is_ecall || in_is_mret) begin
                            state   <= TRAP;
                            exc_q   <= in_is_ecall;
                            ecall_q <= in_is_ecall;
                            mret_q  <= in_is_mret && !in_is_ecall;
                        end else begin
                            state    <= READ;
                            addr_r_q <= in_csr_addr;
                        end
                    end
                end
                READ: begin
                    if (illegal) begin
                        state <= TRAP;
                        exc_q <= 1'b1;
                        ill_q <= 1'b1;
                    end else begin
                        state    <= COMMIT;
                        we_q     <= !suppress;
                        addr_w_q <= suppress ? '0 : addr_q;
                        wdata_q  <= suppress ? '0 : new_val;
                        wb_q     <= 1'b1;
                        wb_rd_q  <= rd_q;
                        old_q    <= csr_rdata;
                    end
                end
                COMMIT: begin
                    state      <= FLUSH;
                    flush_q    <= 1'b1;
                    flush_pc_q <= pc_q + XLEN'(4);
                end
                TRAP: begin
                    state      <= FLUSH;
                    flush_q    <= 1'b1;
                    flush_pc_q <= csr_next_pc;
                end
                FLUSH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset in mid-flight must cancel the strobe already on the wires.
    assign in_ready       = (state == IDLE) && !reset;
    assign csr_addr_read  = addr_r_q;
    assign csr_addr_write = addr_w_q;
    assign csr_wdata      = wdata_q;
    assign csr_we         = we_q && !reset;
    assign trap_exception = exc_q && !reset;
    assign trap_is_ecall  = ecall_q && !reset;
    assign trap_is_mret   = mret_q && !reset;
    assign trap_illegal   = ill_q && !reset;
    assign wb_valid       = wb_q && !reset;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = old_q;
    assign flush_valid    = flush_q && !reset;
    assign flush_pc       = flush_pc_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Randomized self-checking bench for csr_exec_unit with a behavioural CSR file
// and an expected-value model of CSR instruction semantics.
module tb_csr_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_ready;
    logic [2:0]  in_funct3;
    logic        in_is_ecall, in_is_mret;
    logic [11:0] in_csr_addr;
    logic [4:0]  in_src_idx, in_rd;
    logic [63:0] in_rs1_val, in_pc;
    logic [11:0] csr_addr_read, csr_addr_write;
    logic [63:0] csr_wdata, csr_rdata, csr_next_pc;
    logic        csr_we;
    logic        trap_exception, trap_is_ecall, trap_is_mret, trap_illegal;
    logic        wb_valid, flush_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data, flush_pc;

    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [63:0] pre_data = '0;

    bit [63:0] csr_file [4096];
    bit [63:0] ref_csr [4096];

    int total = 0;
    int bad = 0;

    typedef struct {
        int wait_n, ready_cyc, ready_lo;
        int we_n, we_cyc, wb_n, wb_cyc, fl_n, fl_cyc;
        int exc_n, exc_cyc, ecall_cyc, mret_n, mret_cyc, ill_n, ill_cyc;
        logic [11:0] raddr, waddr;
        logic [63:0] wdata, wb_data, fl_pc;
        logic [4:0]  wb_rd;
    } obs_t;

    always #5 clk = ~clk;

    csr_exec_unit #(.XLEN(64), .ADDR_W(12)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret),
        .in_csr_addr(in_csr_addr), .in_src_idx(in_src_idx),
        .in_rs1_val(in_rs1_val), .in_rd(in_rd), .in_pc(in_pc),
        .csr_addr_read(csr_addr_read), .csr_addr_write(csr_addr_write),
        .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_rdata(csr_rdata),
        .trap_exception(trap_exception), .trap_is_ecall(trap_is_ecall),
        .trap_is_mret(trap_is_mret), .trap_illegal(trap_illegal),
        .csr_next_pc(csr_next_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush_valid(flush_valid), .flush_pc(flush_pc)
    );

    // Behavioural CSR register file: combinational read, clocked write.
    assign csr_rdata = csr_file[csr_addr_read];
    always @(posedge clk) begin
        if (pre_we) csr_file[pre_addr] <= pre_data;
        if (csr_we) csr_file[csr_addr_write] <= csr_wdata;
    end

    task automatic preload(input logic [11:0] a, input logic [63:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
        ref_csr[a] = d;
    endtask

    // Architectural effect of one CSR instruction on the expected CSR state.
    task automatic model_csr(input logic [2:0] f3, input logic [11:0] a,
                             input logic [4:0] s, input logic [63:0] r1,
                             output bit wr, output logic [63:0] old,
                             output logic [63:0] nv);
        logic [63:0] operand;
        operand = f3[2] ? 64'(s) : r1;
        old = ref_csr[a];
        case (f3)
            3'd2, 3'd6: nv = old | operand;
            3'd3, 3'd7: nv = old & ~operand;
            default:    nv = operand;
        endcase
        wr = !((f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && s == 5'd0);
        if (wr) ref_csr[a] = nv;
    endtask

    task automatic do_instr(input logic [2:0] f3, input logic ec, input logic mr,
                            input logic [11:0] a, input logic [4:0] s,
                            input logic [63:0] r1, input logic [4:0] rd,
                            input logic [63:0] pc, output obs_t o);
        int n;
        o = '{default: 0};
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        o.wait_n = n;
        if (in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL ready_timeout got=%b need=1", in_ready);
        end
        in_valid = 1'b1; in_funct3 = f3; in_is_ecall = ec; in_is_mret = mr;
        in_csr_addr = a; in_src_idx = s; in_rs1_val = r1; in_rd = rd; in_pc = pc;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 1) o.raddr = csr_addr_read;
            if (in_ready !== 1'b1) o.ready_lo++;
            else if (o.ready_cyc == 0) o.ready_cyc = c;
            if (csr_we) begin
                o.we_n++; o.we_cyc = c; o.waddr = csr_addr_write; o.wdata = csr_wdata;
            end
            if (wb_valid) begin
                o.wb_n++; o.wb_cyc = c; o.wb_rd = wb_rd; o.wb_data = wb_data;
            end
            if (flush_valid) begin
                o.fl_n++; o.fl_cyc = c; o.fl_pc = flush_pc;
            end
            if (trap_exception) begin o.exc_n++; o.exc_cyc = c; end
            if (trap_is_ecall) o.ecall_cyc = c;
            if (trap_is_mret) begin o.mret_n++; o.mret_cyc = c; end
            if (trap_illegal) begin o.ill_n++; o.ill_cyc = c; end
            if (c < 4) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_ready got=%b need=0", in_ready);
        end
        total++;
        if ({csr_we, wb_valid, flush_valid, trap_exception, trap_is_ecall,
             trap_is_mret, trap_illegal} !== 7'b0) begin
            bad++;
            $display("FAIL rst_strobes got=%b need=0", {csr_we, wb_valid, flush_valid,
                     trap_exception, trap_is_ecall, trap_is_mret, trap_illegal});
        end
        total++;
        if ({wb_data, flush_pc, csr_wdata, csr_addr_write, wb_rd} !== '0) begin
            bad++; $display("FAIL rst_data got=%h/%h/%h need=0", wb_data, flush_pc, csr_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_ready_after got=%b need=1", in_ready);
        end
    endtask

    task automatic test_plan_csr;
        obs_t o;
        bit wr;
        logic [63:0] old, nv;
        preload(12'h305, 64'h0);
        model_csr(3'b001, 12'h305, 5'd5, 64'h8000_0000, wr, old, nv);
        do_instr(3'b001, 1'b0, 1'b0, 12'h305, 5'd5, 64'h8000_0000, 5'd1, 64'h1000, o);
        total++;
        if (o.raddr !== 12'h305) begin
            bad++; $display("FAIL rw_raddr got=%h need=305", o.raddr);
        end
        total++;
        if (o.we_n !== 1 || o.we_cyc !== 2 || o.waddr !== 12'h305) begin
            bad++; $display("FAIL rw_we got=n%0d c%0d a%h need=n1 c2 a305", o.we_n, o.we_cyc, o.waddr);
        end
        total++;
        if (o.wdata !== 64'h8000_0000) begin
            bad++; $display("FAIL rw_wdata got=%h need=80000000", o.wdata);
        end
        total++;
        if (o.wb_cyc !== 2 || o.wb_data !== 64'h0 || o.wb_rd !== 5'd1) begin
            bad++; $display("FAIL rw_wb got=c%0d d%h r%0d need=c2 d0 r1", o.wb_cyc, o.wb_data, o.wb_rd);
        end
        total++;
        if (o.fl_n !== 1 || o.fl_cyc !== 3 || o.fl_pc !== 64'h1004) begin
            bad++; $display("FAIL rw_flush got=c%0d pc%h need=c3 pc1004", o.fl_cyc, o.fl_pc);
        end
        total++;
        if (o.ready_cyc !== 4) begin
            bad++; $display("FAIL rw_ready got=%0d need=4", o.ready_cyc);
        end

        preload(12'h300, 64'h1800);
        do_instr(3'b010, 1'b0, 1'b0, 12'h300, 5'd0, 64'hdead_beef, 5'd2, 64'h2000, o);
        total++;
        if (o.we_n !== 0 || o.wb_data !== 64'h1800 || o.wb_cyc !== 2) begin
            bad++; $display("FAIL rs_x0 got=we%0d wb%h need=we0 wb1800", o.we_n, o.wb_data);
        end

        preload(12'h304, 64'hFF);
        do_instr(3'b111, 1'b0, 1'b0, 12'h304, 5'd3, '1, 5'd3, 64'h3000, o);
        total++;
        if (o.we_n !== 1 || o.wdata !== 64'hFC || o.wb_data !== 64'hFF) begin
            bad++; $display("FAIL rci got=we%0d wd%h wb%h need=we1 wdFC wbFF", o.we_n, o.wdata, o.wb_data);
        end
        ref_csr[12'h304] = 64'hFC;
    endtask

    task automatic test_traps;
        obs_t o;
        csr_next_pc = 64'h8000_0000;
        do_instr(3'b000, 1'b1, 1'b0, 12'h0, 5'd0, 64'h0, 5'd0, 64'h100, o);
        total++;
        if (o.exc_n !== 1 || o.exc_cyc !== 1 || o.ecall_cyc !== 1 || o.mret_n !== 0) begin
            bad++; $display("FAIL ecall_strobe got=n%0d c%0d e%0d m%0d need=n1 c1 e1 m0",
                            o.exc_n, o.exc_cyc, o.ecall_cyc, o.mret_n);
        end
        total++;
        if (o.fl_n !== 1 || o.fl_cyc !== 2 || o.fl_pc !== 64'h8000_0000) begin
            bad++; $display("FAIL ecall_flush got=c%0d pc%h need=c2 pc80000000", o.fl_cyc, o.fl_pc);
        end
        total++;
        if (o.wb_n !== 0 || o.we_n !== 0 || o.ready_cyc !== 3) begin
            bad++; $display("FAIL ecall_misc got=wb%0d we%0d rdy%0d need=0 0 3", o.wb_n, o.we_n, o.ready_cyc);
        end
        csr_next_pc = 64'h2468;
        do_instr(3'b001, 1'b0, 1'b1, 12'h305, 5'd1, 64'h5, 5'd1, 64'h400, o);
        total++;
        if (o.mret_n !== 1 || o.mret_cyc !== 1 || o.exc_n !== 0 || o.fl_pc !== 64'h2468
            || o.fl_cyc !== 2 || o.we_n !== 0) begin
            bad++; $display("FAIL mret got=m%0d c%0d x%0d pc%h need=m1 c1 x0 pc2468",
                            o.mret_n, o.mret_cyc, o.exc_n, o.fl_pc);
        end
    endtask

    task automatic test_back_to_back;
        obs_t o;
        preload(12'h340, 64'h0);
        ref_csr[12'h340] = 64'h55;
        do_instr(3'b001, 1'b0, 1'b0, 12'h340, 5'd7, 64'h55, 5'd8, 64'h600, o);
        do_instr(3'b010, 1'b0, 1'b0, 12'h340, 5'd0, 64'h0, 5'd9, 64'h604, o);
        total++;
        if (o.wb_data !== 64'h55 || o.wb_rd !== 5'd9) begin
            bad++; $display("FAIL b2b_raw got=%h r%0d need=55 r9", o.wb_data, o.wb_rd);
        end
        total++;
        if (o.wait_n !== 0 || o.ready_lo !== 3) begin
            bad++; $display("FAIL b2b_ready got=wait%0d lo%0d need=0 3", o.wait_n, o.ready_lo);
        end
    endtask

    task automatic test_reset_commit;
        int seen;
        preload(12'h341, 64'h77);
        in_valid = 1'b1; in_funct3 = 3'b001; in_is_ecall = 1'b0; in_is_mret = 1'b0;
        in_csr_addr = 12'h341; in_src_idx = 5'd1; in_rs1_val = 64'h99; in_rd = 5'd4;
        in_pc = 64'h500;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        total++;
        if (csr_we !== 1'b0 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL rstc_strobe got=we%b wb%b need=0 0", csr_we, wb_valid);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rstc_ready got=%b need=1", in_ready);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (csr_we || wb_valid || flush_valid) seen++;
        end
        total++;
        if (seen !== 0 || csr_file[12'h341] !== 64'h77) begin
            bad++; $display("FAIL rstc_abort got=strobes%0d csr%h need=0 77", seen, csr_file[12'h341]);
        end
    endtask

`ifdef CSR_ILLEGAL_CHECK_EN
    task automatic test_illegal;
        obs_t o;
        csr_next_pc = 64'h1357_9000;
        do_instr(3'b001, 1'b0, 1'b0, 12'hF14, 5'd3, 64'h1, 5'd5, 64'h700, o);
        total++;
        if (o.ill_n !== 1 || o.ill_cyc !== 2 || o.exc_cyc !== 2 || o.we_n !== 0 || o.wb_n !== 0) begin
            bad++; $display("FAIL illegal_ro got=i%0d c%0d x%0d we%0d wb%0d need=1 2 2 0 0",
                            o.ill_n, o.ill_cyc, o.exc_cyc, o.we_n, o.wb_n);
        end
        total++;
        if (o.fl_cyc !== 3 || o.fl_pc !== 64'h1357_9000) begin
            bad++; $display("FAIL illegal_flush got=c%0d pc%h need=c3 pc13579000", o.fl_cyc, o.fl_pc);
        end
    endtask
`else
    task automatic test_undef_funct3;
        obs_t o;
        preload(12'h343, 64'h1111);
        do_instr(3'b000, 1'b0, 1'b0, 12'h343, 5'd0, 64'hABCD, 5'd6, 64'h800, o);
        total++;
        if (o.we_n !== 1 || o.wdata !== 64'hABCD || o.wb_data !== 64'h1111 || o.ill_n !== 0) begin
            bad++; $display("FAIL undef_rw got=we%0d wd%h wb%h need=we1 wdABCD wb1111",
                            o.we_n, o.wdata, o.wb_data);
        end
        ref_csr[12'h343] = 64'hABCD;
    endtask
`endif

    task automatic test_random;
        obs_t o;
        bit wr;
        logic [63:0] old, nv, pc, r1;
        logic [11:0] a;
        logic [4:0] s, rd;
        logic [2:0] f3;
        logic [11:0] addrs [10];
        logic [2:0] ops [6];
        addrs = '{12'h300, 12'h305, 12'h344, 12'h304, 12'h340,
                  12'h342, 12'h343, 12'h341, 12'hB00, 12'h180};
        ops = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 10; i++) preload(addrs[i], {$urandom, $urandom});
        for (int i = 0; i < 40; i++) begin
            a  = addrs[$urandom_range(0, 9)];
            f3 = ops[$urandom_range(0, 5)];
            s  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd = 5'($urandom);
            r1 = {$urandom, $urandom};
            pc = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) begin
                csr_next_pc = {$urandom, $urandom};
                do_instr(f3, 1'b1, 1'b0, a, s, r1, rd, pc, o);
                total++;
                if (o.ecall_cyc !== 1 || o.fl_cyc !== 2 || o.fl_pc !== csr_next_pc
                    || o.we_n !== 0 || o.wb_n !== 0 || o.ready_cyc !== 3) begin
                    bad++; $display("FAIL rnd_ecall[%0d] got=e%0d f%0d pc%h need=e1 f2 pc%h",
                                    i, o.ecall_cyc, o.fl_cyc, o.fl_pc, csr_next_pc);
                end
            end else begin
                model_csr(f3, a, s, r1, wr, old, nv);
                do_instr(f3, 1'b0, 1'b0, a, s, r1, rd, pc, o);
                total++;
                if (o.wb_n !== 1 || o.wb_cyc !== 2 || o.wb_data !== old || o.wb_rd !== rd) begin
                    bad++; $display("FAIL rnd_wb[%0d] got=c%0d d%h r%0d need=c2 d%h r%0d",
                                    i, o.wb_cyc, o.wb_data, o.wb_rd, old, rd);
                end
                total++;
                if (o.we_n !== int'(wr) || (wr && (o.we_cyc !== 2 || o.wdata !== nv || o.waddr !== a))) begin
                    bad++; $display("FAIL rnd_we[%0d] got=n%0d d%h a%h need=n%0d d%h a%h",
                                    i, o.we_n, o.wdata, o.waddr, wr, nv, a);
                end
                total++;
                if (o.fl_n !== 1 || o.fl_cyc !== 3 || o.fl_pc !== pc + 64'd4 || o.ready_cyc !== 4) begin
                    bad++; $display("FAIL rnd_flush[%0d] got=c%0d pc%h rdy%0d need=c3 pc%h rdy4",
                                    i, o.fl_cyc, o.fl_pc, o.ready_cyc, pc + 64'd4);
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (csr_file[addrs[i]] !== ref_csr[addrs[i]]) begin
                bad++; $display("FAIL rnd_final[%h] got=%h need=%h",
                                addrs[i], csr_file[addrs[i]], ref_csr[addrs[i]]);
            end
        end
    endtask

    initial begin
        in_valid = 1'b0; in_funct3 = '0; in_is_ecall = 1'b0; in_is_mret = 1'b0;
        in_csr_addr = '0; in_src_idx = '0; in_rs1_val = '0; in_rd = '0; in_pc = '0;
        csr_next_pc = '0;
        test_reset;
        test_plan_csr;
        test_traps;
        test_back_to_back;
        test_reset_commit;
`ifdef CSR_ILLEGAL_CHECK_EN
        test_illegal;
`else
        test_undef_funct3;
`endif
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
